// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous imem, and holds the F/D register.
// Build option FETCH_SKID_EN: a one-entry skid buffer holds the in-flight word during a stall; without it the PC rewinds and replays.
module fetch_unit #(
    parameter int              PC_W     = 12,
    parameter int              INSN_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INSN_W-1:0] imem_q,
    input  logic              stall,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              fd_valid,
    output logic [INSN_W-1:0] fd_insn,
    output logic [4:0]        fd_opcode,
    output logic [PC_W-1:0]   fd_pc,
    output logic [PC_W-1:0]   fd_pc_plus1
);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              req_v_q, req_v_d;
    logic [PC_W-1:0]   req_pc_q, req_pc_d;
    logic              fd_valid_q, fd_valid_d;
    logic [INSN_W-1:0] fd_insn_q, fd_insn_d;
    logic [PC_W-1:0]   fd_pc_q, fd_pc_d;

`ifdef FETCH_SKID_EN
    logic              sk_v_q, sk_v_d;
    logic [INSN_W-1:0] sk_insn_q, sk_insn_d;
    logic [PC_W-1:0]   sk_pc_q, sk_pc_d;
`endif

    always_comb begin
        pc_d       = pc_q;
        req_v_d    = 1'b0;
        req_pc_d   = req_pc_q;
        fd_valid_d = fd_valid_q;
        fd_insn_d  = fd_insn_q;
        fd_pc_d    = fd_pc_q;
`ifdef FETCH_SKID_EN
        sk_v_d     = sk_v_q;
        sk_insn_d  = sk_insn_q;
        sk_pc_d    = sk_pc_q;
`endif

        if (redirect) begin
            // Redirect wins over stall: whatever sits in F/D or in flight is wrong-path.
            pc_d       = redirect_pc;
            fd_valid_d = 1'b0;
`ifdef FETCH_SKID_EN
            sk_v_d     = 1'b0;
`endif
        end else if (!stall) begin
            pc_d     = pc_q + PC_W'(1);
            req_v_d  = 1'b1;
            req_pc_d = pc_q;
`ifdef FETCH_SKID_EN
            if (sk_v_q) begin
                fd_valid_d = 1'b1;
                fd_insn_d  = sk_insn_q;
                fd_pc_d    = sk_pc_q;
                sk_v_d     = 1'b0;
            end else begin
                fd_valid_d = req_v_q;
                fd_insn_d  = imem_q;
                fd_pc_d    = req_pc_q;
            end
`else
            fd_valid_d = req_v_q;
            fd_insn_d  = imem_q;
            fd_pc_d    = req_pc_q;
`endif
        end else if (req_v_q) begin
`ifdef FETCH_SKID_EN
            sk_v_d    = 1'b1;
            sk_insn_d = imem_q;
            sk_pc_d   = req_pc_q;
`else
            // Drop the returning word and reissue its address once the stall clears.
            pc_d = req_pc_q;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            req_v_q    <= 1'b0;
            req_pc_q   <= '0;
            fd_valid_q <= 1'b0;
            fd_insn_q  <= '0;
            fd_pc_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_v_q    <= req_v_d;
            req_pc_q   <= req_pc_d;
            fd_valid_q <= fd_valid_d;
            fd_insn_q  <= fd_insn_d;
            fd_pc_q    <= fd_pc_d;
        end
    end

`ifdef FETCH_SKID_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sk_v_q    <= 1'b0;
            sk_insn_q <= '0;
            sk_pc_q   <= '0;
        end else begin
            sk_v_q    <= sk_v_d;
            sk_insn_q <= sk_insn_d;
            sk_pc_q   <= sk_pc_d;
        end
    end

    // The skid only fills during a stall, which suppresses the next request.
    a_req_skid_exclusive: assert property (@(posedge clock) disable iff (!reset_n)
        !(req_v_q && sk_v_q));
`endif

    assign imem_addr   = pc_q;
    assign fd_valid    = fd_valid_q;
    assign fd_insn     = fd_insn_q;
    assign fd_opcode   = fd_insn_q[31:27];
    assign fd_pc       = fd_pc_q;
    assign fd_pc_plus1 = fd_pc_q + PC_W'(1);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; imem word i holds 0x1000_0000+i. Expectations follow FETCH_SKID_EN when defined.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] imem_addr;
    logic [31:0] imem_q = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [11:0] redirect_pc = 12'h0;
    logic        fd_valid;
    logic [31:0] fd_insn;
    logic [4:0]  fd_opcode;
    logic [11:0] fd_pc;
    logic [11:0] fd_pc_plus1;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    fetch_unit #(.PC_W(12), .INSN_W(32), .RESET_PC(12'h000)) dut (
        .clock(clock), .reset_n(reset_n), .imem_addr(imem_addr), .imem_q(imem_q),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .fd_valid(fd_valid), .fd_insn(fd_insn), .fd_opcode(fd_opcode),
        .fd_pc(fd_pc), .fd_pc_plus1(fd_pc_plus1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) imem_q <= 32'h1000_0000 + {20'b0, imem_addr};

    logic [61:0] act;
    assign act = {fd_valid, fd_pc, fd_insn, fd_opcode, fd_pc_plus1};

    localparam logic [61:0] RESET_VEC = {1'b0, 12'h000, 32'h0, 5'h0, 12'h001};

    function automatic logic [61:0] fd_model(input logic [11:0] p);
        logic [31:0] w;
        w = 32'h1000_0000 + {20'b0, p};
        return {1'b1, p, w, w[31:27], p + 12'd1};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 12'h000;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic test_reset();
        #1;
        nvec++;
        if (act !== RESET_VEC) begin
            nerr++; $display("FAIL reset_fd got %h want %h", act, RESET_VEC);
        end
        nvec++;
        if (imem_addr !== 12'h000) begin
            nerr++; $display("FAIL reset_addr got %h want 000", imem_addr);
        end
        do_reset();
        nvec++;
        if (imem_addr !== 12'h000 || fd_valid !== 1'b0) begin
            nerr++; $display("FAIL cycle0 addr=%h valid=%b want 000/0", imem_addr, fd_valid);
        end
    endtask

    task automatic test_stream();
        logic [11:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_pc = 12'(cyc - 2);
            nvec++;
            if (imem_addr !== 12'(cyc)) begin
                nerr++; $display("FAIL stream_addr cyc=%0d got %h want %h", cyc, imem_addr, 12'(cyc));
            end
            nvec++;
            if (cyc >= 2) begin
                if (act !== fd_model(exp_pc)) begin
                    nerr++; $display("FAIL stream cyc=%0d got %h want %h", cyc, act, fd_model(exp_pc));
                end
            end else if (fd_valid !== 1'b0) begin
                nerr++; $display("FAIL stream cyc=%0d fd_valid got %b want 0", cyc, fd_valid);
            end
        end
    endtask

    task automatic test_stall_single();
        logic        exp_v;
        logic [11:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            tick();
            stall  = (cyc == 5);
            exp_v  = (cyc >= 2);
            exp_pc = 12'(cyc - 2);
            if (cyc == 6) exp_pc = 12'd3;
`ifdef FETCH_SKID_EN
            if (cyc >= 7) exp_pc = 12'(cyc - 3);
`else
            if (cyc == 7) exp_v = 1'b0;
            if (cyc >= 8) exp_pc = 12'(cyc - 4);
`endif
            nvec++;
            if (exp_v) begin
                if (act !== fd_model(exp_pc)) begin
                    nerr++; $display("FAIL stall1 cyc=%0d got %h want %h", cyc, act, fd_model(exp_pc));
                end
            end else if (fd_valid !== 1'b0) begin
                nerr++; $display("FAIL stall1 cyc=%0d fd_valid got %b want 0", cyc, fd_valid);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_stall_multi();
        logic        exp_v;
        logic [11:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            tick();
            stall  = (cyc >= 5 && cyc <= 8);
            exp_v  = (cyc >= 2);
            exp_pc = 12'(cyc - 2);
            if (cyc >= 6 && cyc <= 9) exp_pc = 12'd3;
`ifdef FETCH_SKID_EN
            if (cyc >= 10) exp_pc = 12'(cyc - 6);
            nvec++;
            if (dut.req_v_q && dut.sk_v_q) begin
                nerr++; $display("FAIL req_skid_both cyc=%0d got 1 want 0", cyc);
            end
            if (cyc >= 6 && cyc <= 9) begin
                nvec++;
                if (dut.sk_v_q !== 1'b1) begin
                    nerr++; $display("FAIL sk_v cyc=%0d got %b want 1", cyc, dut.sk_v_q);
                end
                nvec++;
                if (imem_addr !== 12'd5) begin
                    nerr++; $display("FAIL stall4_addr cyc=%0d got %h want 005", cyc, imem_addr);
                end
            end
`else
            if (cyc == 10) exp_v = 1'b0;
            if (cyc >= 11) exp_pc = 12'(cyc - 7);
            if (cyc >= 6 && cyc <= 9) begin
                nvec++;
                if (imem_addr !== 12'd4) begin
                    nerr++; $display("FAIL rewind_addr cyc=%0d got %h want 004", cyc, imem_addr);
                end
            end
`endif
            nvec++;
            if (exp_v) begin
                if (act !== fd_model(exp_pc)) begin
                    nerr++; $display("FAIL stall4 cyc=%0d got %h want %h", cyc, act, fd_model(exp_pc));
                end
            end else if (fd_valid !== 1'b0) begin
                nerr++; $display("FAIL stall4 cyc=%0d fd_valid got %b want 0", cyc, fd_valid);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect();
        logic        exp_v;
        logic [11:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 15; c++) begin
            tick();
            redirect    = (cyc == 10);
            redirect_pc = 12'h080;
            exp_v  = (cyc >= 2) && !(cyc == 11 || cyc == 12);
            exp_pc = (cyc >= 13) ? 12'h080 + 12'(cyc - 13) : 12'(cyc - 2);
            if (cyc == 11) begin
                nvec++;
                if (imem_addr !== 12'h080) begin
                    nerr++; $display("FAIL redirect_addr got %h want 080", imem_addr);
                end
            end
            nvec++;
            if (exp_v) begin
                if (act !== fd_model(exp_pc)) begin
                    nerr++; $display("FAIL redirect cyc=%0d got %h want %h", cyc, act, fd_model(exp_pc));
                end
            end else if (fd_valid !== 1'b0) begin
                nerr++; $display("FAIL redirect cyc=%0d fd_valid got %b want 0", cyc, fd_valid);
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_collision();
        logic        exp_v;
        logic [11:0] exp_pc;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            tick();
            stall       = (cyc >= 5 && cyc <= 7);
            redirect    = (cyc == 6);
            redirect_pc = 12'h200;
            exp_v  = (cyc >= 2) && !(cyc >= 7 && cyc <= 9);
            exp_pc = (cyc >= 10) ? 12'h200 + 12'(cyc - 10) : 12'(cyc - 2);
            if (cyc == 6) exp_pc = 12'd3;
`ifdef FETCH_SKID_EN
            if (cyc == 6 || cyc == 7) begin
                nvec++;
                if (dut.sk_v_q !== (cyc == 6)) begin
                    nerr++; $display("FAIL collide_sk_v cyc=%0d got %b want %b", cyc, dut.sk_v_q, (cyc == 6));
                end
            end
`endif
            if (cyc == 7 || cyc == 8) begin
                nvec++;
                if (imem_addr !== 12'h200) begin
                    nerr++; $display("FAIL collide_addr cyc=%0d got %h want 200", cyc, imem_addr);
                end
            end
            nvec++;
            if (exp_v) begin
                if (act !== fd_model(exp_pc)) begin
                    nerr++; $display("FAIL collide cyc=%0d got %h want %h", cyc, act, fd_model(exp_pc));
                end
            end else if (fd_valid !== 1'b0) begin
                nerr++; $display("FAIL collide cyc=%0d fd_valid got %b want 0", cyc, fd_valid);
            end
        end
        stall    = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic test_wrap();
        logic        exp_v;
        logic [11:0] exp_pc;
        logic [11:0] exp_addr;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            tick();
            redirect    = (cyc == 3);
            redirect_pc = 12'hFFE;
            exp_v  = (cyc >= 2) && !(cyc == 4 || cyc == 5);
            exp_pc = (cyc >= 6) ? 12'hFFE + 12'(cyc - 6) : 12'(cyc - 2);
            if (cyc >= 4 && cyc <= 6) begin
                exp_addr = 12'hFFE + 12'(cyc - 4);
                nvec++;
                if (imem_addr !== exp_addr) begin
                    nerr++; $display("FAIL wrap_addr cyc=%0d got %h want %h", cyc, imem_addr, exp_addr);
                end
            end
            nvec++;
            if (exp_v) begin
                if (act !== fd_model(exp_pc)) begin
                    nerr++; $display("FAIL wrap cyc=%0d got %h want %h", cyc, act, fd_model(exp_pc));
                end
            end else if (fd_valid !== 1'b0) begin
                nerr++; $display("FAIL wrap cyc=%0d fd_valid got %b want 0", cyc, fd_valid);
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            tick();
            stall = (cyc >= 5);
        end
        #2;
        reset_n = 1'b0;
        #1;
        nvec++;
        if (act !== RESET_VEC) begin
            nerr++; $display("FAIL async_reset_fd got %h want %h", act, RESET_VEC);
        end
        nvec++;
        if (imem_addr !== 12'h000) begin
            nerr++; $display("FAIL async_reset_addr got %h want 000", imem_addr);
        end
`ifdef FETCH_SKID_EN
        nvec++;
        if (dut.sk_v_q !== 1'b0) begin
            nerr++; $display("FAIL async_reset_sk_v got %b want 0", dut.sk_v_q);
        end
`endif
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            tick();
            nvec++;
            if (cyc >= 2) begin
                if (act !== fd_model(12'(cyc - 2))) begin
                    nerr++; $display("FAIL post_reset cyc=%0d got %h want %h", cyc, act, fd_model(12'(cyc - 2)));
                end
            end else if (fd_valid !== 1'b0) begin
                nerr++; $display("FAIL post_reset cyc=%0d fd_valid got %b want 0", cyc, fd_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_single();
        test_stall_multi();
        test_redirect();
        test_collision();
        test_wrap();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
